seq_mult_arbiter: RTL and testbench
===================================

SEQ_MULT_ARBITER -- requirements
Module: seq_mult_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters (2..8).
REQ-002 SHALL have parameter P, default 2: product digit width per seq_mult output beat.
REQ-003 SHALL have parameter TIMEOUT, default 255: watchdog limit in cycles; used only with SEQ_ARB_TIMEOUT_EN.
REQ-004 SHALL have port clk  in  1  the single clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  N  per-requester request valid.
REQ-007 SHALL have port req_ready  out  N  per-requester request accept, one-hot or zero.
REQ-008 SHALL have port req_a / req_b  in  N*16 each  operands, slice i belongs to requester i.
REQ-009 SHALL have port req_bitsize  in  N*4  operand length in P-bit digits, slice i for requester i.
REQ-010 SHALL have port resp_valid  out  N  one-hot response valid to the owning requester.
REQ-011 SHALL have port resp_ready  in  N  per-requester response accept.
REQ-012 SHALL have port resp_prod  out  32  product, right-aligned, shared by all requesters.
REQ-013 SHALL have port resp_err  out  1  response flagged as aborted or malformed.
REQ-014 SHALL have ports mult_start out 1, mult_a out 16, mult_b out 16, mult_bitsize out 4: drive seq_mult.
REQ-015 SHALL have ports mult_p in P, mult_newout in 1, mult_done in 1: from seq_mult.
REQ-016 SHALL have port busy  out  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> LAUNCH -> RUN -> RESP -> IDLE.
REQ-018 IDLE: if any req_valid, grant lowest index at or after rr_ptr (wrapping); assert req_ready[g] combinationally that cycle; latch a, b, bitsize, g; go LAUNCH.
REQ-019 rr_ptr SHALL become g+1 mod N on each grant.
REQ-020 LAUNCH: mult_start=1 for exactly one cycle with latched operands; clear acc and beat count; go RUN.
REQ-021 mult_a, mult_b, mult_bitsize SHALL hold latched values from LAUNCH until leaving RUN.
REQ-022 RUN: on each mult_newout, acc <= {mult_p, acc[31:P]} and beat count +1.
REQ-023 RUN: on mult_done, resp_prod <= acc (including same-cycle beat) >> (32 - P*beats); go RESP.
REQ-024 mult_newout and mult_done in the same cycle: beat SHALL be included before alignment.
REQ-025 Beats beyond 32/P SHALL be dropped and resp_err set.
REQ-026 Granted bitsize 0: skip LAUNCH/RUN, go RESP with resp_prod=0, resp_err=1.
REQ-027 RESP: resp_valid[g]=1, resp_prod/resp_err stable until resp_ready[g]; then IDLE, no new grant that cycle.
REQ-028 mult_newout/mult_done outside RUN SHALL be ignored.
REQ-029 Total latency grant -> resp_valid SHALL be seq_mult latency + 2 cycles.

Reset
REQ-030 Async on rst_n low, including mid-operation: state IDLE, rr_ptr 0, acc 0, resp_prod 0, resp_err 0.
REQ-031 During reset all outputs SHALL be 0: req_ready, resp_valid, mult_start, mult_a, mult_b, mult_bitsize, busy.
REQ-032 A transaction interrupted by reset SHALL be lost without response.

Configuration
REQ-033 Macro SEQ_ARB_TIMEOUT_EN defined: counter in RUN; after TIMEOUT cycles without mult_done, go RESP with resp_err=1, resp_prod=0.
REQ-034 SEQ_ARB_TIMEOUT_EN undefined: no counter; RUN waits for mult_done indefinitely; resp_err only from REQ-025/026.

Verification
REQ-035 Req0 a=0x002D, b=0x009D, bitsize=4, P=2 -> one mult_start, resp_valid[0], resp_prod=0x00001B99, resp_err=0.
REQ-036 All four req_valid held high, rr_ptr=0 -> grants 0,1,2,3,0 in order; exactly one req_ready per grant.
REQ-037 Req2 bitsize=0 -> no mult_start, resp_valid[2] next-but-one cycle, resp_prod=0, resp_err=1.
REQ-038 resp_ready held low 10 cycles in RESP -> resp_valid and resp_prod stable; req_ready stays 0.
REQ-039 rst_n low in RUN mid-product -> all outputs 0 immediately; after release, new req1 request completes correctly.
REQ-040 With SEQ_ARB_TIMEOUT_EN and TIMEOUT=20, mult_done never asserted -> resp_valid after 20 RUN cycles, resp_err=1.

Source files
------------

// File: rtl/seq_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_arbiter
// Purpose  : Round-robin front end that shares one sequential multiplier
//            (seq_mult) between N requesters. It collects the P-bit product
//            digits streamed by the multiplier, right-aligns them and returns
//            the product to the requester that owns the current slot.
// Options  : SEQ_ARB_TIMEOUT_EN - adds a RUN-state watchdog of TIMEOUT cycles.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_arbiter #(
  parameter int N       = 4,
  parameter int P       = 2,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*16-1:0] req_a,
  input  logic [N*16-1:0] req_b,
  input  logic [N*4-1:0]  req_bitsize,
  output logic [N-1:0]    resp_valid,
  input  logic [N-1:0]    resp_ready,
  output logic [31:0]     resp_prod,
  output logic            resp_err,
  output logic            mult_start,
  output logic [15:0]     mult_a,
  output logic [15:0]     mult_b,
  output logic [3:0]      mult_bitsize,
  input  logic [P-1:0]    mult_p,
  input  logic            mult_newout,
  input  logic            mult_done,
  output logic            busy
);

  localparam int IW   = (N > 1) ? $clog2(N) : 1;
  localparam int MAXB = 32 / P;
  localparam int BW   = $clog2(MAXB + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t        state_q;
  logic [IW-1:0] rr_ptr_q;
  logic [IW-1:0] gnt_q;
  logic [31:0]   acc_q, acc_d;
  logic [BW-1:0] beats_q, beats_d;
  logic          ovf_q, ovf_d;
  logic [N-1:0]  resp_valid_q;
  logic [31:0]   resp_prod_q;
  logic          resp_err_q;
  logic          mult_start_q;
  logic [15:0]   mult_a_q, mult_b_q;
  logic [3:0]    mult_bs_q;

  logic [N-1:0]  req_rot;
  logic          req_any;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  gnt_oh;
  logic [N-1:0]  own_oh;
  logic [15:0]   sel_a, sel_b;
  logic [3:0]    sel_bs;
  logic [6:0]    shamt;
  logic [31:0]   aligned;
  logic          tmo_hit;

  // Parameter ranges the datapath cannot support stop elaboration
  if (N < 2 || N > 8 || P < 1 || (32 % P) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("seq_mult_arbiter: unsupported parameter combination");
  end

  // Rotating priority: lowest requester index at or after rr_ptr_q wins
  always_comb begin
    req_rot = N'({req_valid, req_valid} >> rr_ptr_q);
    req_any = |req_valid;
    gnt_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        if (int'(rr_ptr_q) + k >= N) gnt_idx = IW'(int'(rr_ptr_q) + k - N);
        else                         gnt_idx = IW'(int'(rr_ptr_q) + k);
      end
    end
  end

  // One-hot views of the candidate grant and the slot owner, plus operand select
  always_comb begin
    gnt_oh          = '0;
    gnt_oh[gnt_idx] = 1'b1;
    own_oh          = '0;
    own_oh[gnt_q]   = 1'b1;
    sel_a           = req_a[16*gnt_idx +: 16];
    sel_b           = req_b[16*gnt_idx +: 16];
    sel_bs          = req_bitsize[4*gnt_idx +: 4];
  end

  // Digit collection: a beat arriving with done is folded in before alignment
  always_comb begin
    acc_d   = acc_q;
    beats_d = beats_q;
    ovf_d   = ovf_q;
    if (mult_newout) begin
      if (beats_q == BW'(MAXB)) begin
        ovf_d = 1'b1;
      end else begin
        acc_d   = {mult_p, acc_q[31:P]};
        beats_d = beats_q + BW'(1);
      end
    end
    shamt   = 7'(32 - P * int'(beats_d));
    aligned = acc_d >> shamt;
  end

`ifdef SEQ_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] tmo_q;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  // Watchdog counts RUN cycles and restarts whenever RUN is left
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                tmo_q <= '0;
    else if (state_q != S_RUN) tmo_q <= '0;
    else if (!tmo_hit)         tmo_q <= tmo_q + TW'(1);
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Main controller: grant, launch, collect digits, hold response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      acc_q        <= '0;
      beats_q      <= '0;
      ovf_q        <= 1'b0;
      resp_valid_q <= '0;
      resp_prod_q  <= '0;
      resp_err_q   <= 1'b0;
      mult_start_q <= 1'b0;
      mult_a_q     <= '0;
      mult_b_q     <= '0;
      mult_bs_q    <= '0;
    end else begin
      mult_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_any) begin
            gnt_q    <= gnt_idx;
            rr_ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
            if (sel_bs == 4'd0) begin
              resp_prod_q  <= '0;
              resp_err_q   <= 1'b1;
              resp_valid_q <= gnt_oh;
              state_q      <= S_RESP;
            end else begin
              mult_a_q     <= sel_a;
              mult_b_q     <= sel_b;
              mult_bs_q    <= sel_bs;
              mult_start_q <= 1'b1;
              state_q      <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          acc_q   <= '0;
          beats_q <= '0;
          ovf_q   <= 1'b0;
          state_q <= S_RUN;
        end
        S_RUN: begin
          acc_q   <= acc_d;
          beats_q <= beats_d;
          ovf_q   <= ovf_d;
          if (mult_done || tmo_hit) begin
            resp_prod_q  <= mult_done ? aligned : '0;
            resp_err_q   <= mult_done ? ovf_d : 1'b1;
            resp_valid_q <= own_oh;
            mult_a_q     <= '0;
            mult_b_q     <= '0;
            mult_bs_q    <= '0;
            state_q      <= S_RESP;
          end
        end
        S_RESP: begin
          if ((resp_valid_q & resp_ready) != '0) begin
            resp_valid_q <= '0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready    = (rst_n && state_q == S_IDLE && req_any) ? gnt_oh : '0;
  assign resp_valid   = resp_valid_q;
  assign resp_prod    = resp_prod_q;
  assign resp_err     = resp_err_q;
  assign mult_start   = mult_start_q;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;
  assign mult_bitsize = mult_bs_q;
  assign busy         = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_mult_arbiter
// Purpose  : Scoreboard bench for seq_mult_arbiter with a behavioural seq_mult
//            that streams 2*bitsize P-bit digits LSB first, done on the last.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_mult_arbiter;

  localparam int N       = 4;
  localparam int P       = 2;
  localparam int TIMEOUT = 20;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*16-1:0] req_a = '0;
  logic [N*16-1:0] req_b = '0;
  logic [N*4-1:0]  req_bitsize = '0;
  logic [N-1:0]    resp_valid;
  logic [N-1:0]    resp_ready = '1;
  logic [31:0]     resp_prod;
  logic            resp_err;
  logic            mult_start;
  logic [15:0]     mult_a, mult_b;
  logic [3:0]      mult_bitsize;
  logic [P-1:0]    mult_p = '0;
  logic            mult_newout = 1'b0;
  logic            mult_done = 1'b0;
  logic            busy;

  seq_mult_arbiter #(.N(N), .P(P), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_bitsize(req_bitsize),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_prod(resp_prod), .resp_err(resp_err),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_bitsize(mult_bitsize),
    .mult_p(mult_p), .mult_newout(mult_newout), .mult_done(mult_done),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] prod;
    logic        err;
    int          lat;
    int          gcyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          glog[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_starts = 0;
  int          mon_g;
  logic [15:0] tab_a [N];
  logic [15:0] tab_b [N];
  int          tab_k [N];
  bit          hang_mode = 1'b0;
  bit          auto_drop = 1'b1;
  bit          grant_pending = 1'b0;
  int          last_g = 0;
  logic [N-1:0] prev_rv = '0;
  logic [31:0] m_sh = '0;
  int          m_left = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {err, prod} for operands truncated to P*k bits; 2k digits, 32/P kept
  function automatic logic [32:0] exp_of(input logic [15:0] a, input logic [15:0] b, input int k);
    logic [15:0] m;
    logic [31:0] pr;
    if (k == 0) return {1'b1, 32'h0};
    m  = (P * k >= 16) ? 16'hFFFF : 16'((32'h1 << (P * k)) - 1);
    pr = 32'(a & m) * 32'(b & m);
    return {(2 * k > 32 / P), pr};
  endfunction

  task automatic post(input int i, input logic [15:0] a, input logic [15:0] b, input int k);
    tab_a[i] = a;
    tab_b[i] = b;
    tab_k[i] = k;
    req_a[16*i +: 16]      = a;
    req_b[16*i +: 16]      = b;
    req_bitsize[4*i +: 4]  = 4'(k);
    req_valid[i]           = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if (req_valid == '0 && sb.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 64'(ok), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_resp_valid"}, 64'(resp_valid), 64'(0));
    check({tag, "_mult_start"}, 64'(mult_start), 64'(0));
    check({tag, "_mult_ops"}, 64'({mult_a, mult_b, mult_bitsize}), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_resp"}, 64'({resp_err, resp_prod}), 64'(0));
  endtask

  always @(posedge clk) cyc++;

  // Behavioural seq_mult
  always @(negedge clk) begin
    mult_newout = 1'b0;
    mult_done   = 1'b0;
    mult_p      = '0;
    if (!rst_n) begin
      m_left = 0;
    end else if (mult_start) begin
      n_starts++;
      m_sh   = exp_of(mult_a, mult_b, int'(mult_bitsize))[31:0];
      m_left = hang_mode ? 0 : 2 * int'(mult_bitsize);
    end else if (m_left > 0) begin
      mult_newout = 1'b1;
      mult_p      = m_sh[P-1:0];
      m_sh        = m_sh >> P;
      m_left--;
      if (m_left == 0) mult_done = 1'b1;
    end
  end

  // Release a requester once its grant edge has passed
  always @(posedge clk) begin
    #1;
    if (grant_pending && auto_drop) req_valid[last_g] = 1'b0;
    grant_pending = 1'b0;
  end

  // Grant observer and response scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (req_ready != '0) begin
        check("rdy_onehot", 64'($countones(req_ready)), 64'(1));
        mon_g = 0;
        for (int i = 0; i < N; i++) if (req_ready[i]) mon_g = i;
        check("rdy_has_valid", 64'(req_valid[mon_g]), 64'(1));
        mon_e.idx  = mon_g;
        {mon_e.err, mon_e.prod} = hang_mode ? {1'b1, 32'h0} :
                                  exp_of(tab_a[mon_g], tab_b[mon_g], tab_k[mon_g]);
        mon_e.lat  = (tab_k[mon_g] == 0) ? 0 :
                     (hang_mode ? TIMEOUT + 2 : 2 * tab_k[mon_g] + 2);
        mon_e.gcyc = cyc;
        sb.push_back(mon_e);
        glog.push_back(mon_g);
        grant_pending = 1'b1;
        last_g        = mon_g;
      end
      if (resp_valid != '0 && prev_rv == '0) begin
        if (sb.size() == 0)
          check("spurious_resp", 64'(resp_valid), 64'(0));
        else if (sb[0].lat == 0)
          check("lat_bs0", 64'((cyc - sb[0].gcyc) >= 1 && (cyc - sb[0].gcyc) <= 2), 64'(1));
        else
          check("latency", 64'(cyc - sb[0].gcyc), 64'(sb[0].lat));
      end
      if ((resp_valid & resp_ready) != '0 && sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("resp_owner", 64'(resp_valid), 64'(1) << mon_e.idx);
        check("resp_prod", 64'(resp_prod), 64'(mon_e.prod));
        check("resp_err", 64'(resp_err), 64'(mon_e.err));
      end
    end
    prev_rv = resp_valid;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "time limit");
  end

  initial begin
    int s0;
    int bad_v, bad_p, bad_r;
    logic [32:0] hx;
    // Outputs during reset, even with a request pending
    for (int i = 0; i < N; i++) begin
      tab_a[i] = '0; tab_b[i] = '0; tab_k[i] = 0;
    end
    post(0, 16'h0001, 16'h0001, 1);
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    req_valid = '0;
    rst_n     = 1'b1;

    // Basic product, single launch
    s0 = n_starts;
    post(0, 16'h002D, 16'h009D, 4);
    wait_idle("idle_basic");
    check("basic_starts", 64'(n_starts - s0), 64'(1));

    // Round-robin order with every requester asserting
    do_reset();
    glog.delete();
    auto_drop = 1'b0;
    post(0, 16'h0003, 16'h0002, 1);
    post(1, 16'h0001, 16'h0003, 1);
    post(2, 16'h0002, 16'h0002, 1);
    post(3, 16'h0003, 16'h0003, 1);
    for (int i = 0; i < 200 && glog.size() < 5; i++) begin
      @(posedge clk); #1;
    end
    req_valid = '0;
    auto_drop = 1'b1;
    check("rr_count", 64'(glog.size() >= 5), 64'(1));
    for (int i = 0; i < 5 && i < glog.size(); i++)
      check("rr_order", 64'(glog[i]), 64'(i % 4));
    wait_idle("idle_rr");

    // Zero bitsize bypasses the multiplier
    s0 = n_starts;
    post(2, 16'h1234, 16'h5678, 0);
    wait_idle("idle_bs0");
    check("bs0_starts", 64'(n_starts - s0), 64'(0));

    // Response held by back-pressure while another request waits
    resp_ready[1] = 1'b0;
    post(1, 16'h1234, 16'h00FF, 3);
    s0 = 0;
    for (int i = 0; i < 100 && s0 == 0; i++) begin
      @(negedge clk);
      if (resp_valid[1]) s0 = 1;
    end
    check("hold_seen", 64'(s0), 64'(1));
    post(3, 16'hFFFF, 16'hFFFF, 8);
    hx = exp_of(16'h1234, 16'h00FF, 3);
    bad_v = 0; bad_p = 0; bad_r = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (resp_valid !== 4'b0010) bad_v++;
      if (resp_prod !== hx[31:0]) bad_p++;
      if (req_ready !== '0) bad_r++;
    end
    check("hold_valid", 64'(bad_v), 64'(0));
    check("hold_prod", 64'(bad_p), 64'(0));
    check("hold_no_grant", 64'(bad_r), 64'(0));
    @(posedge clk); #1 resp_ready[1] = 1'b1;
    wait_idle("idle_hold");

    // More digits than the product register holds
    post(0, 16'hABCD, 16'h1357, 12);
    wait_idle("idle_ovf");

    // Reset in the middle of a product
    post(1, 16'h00FF, 16'h00FF, 8);
    s0 = 0;
    for (int i = 0; i < 50 && s0 == 0; i++) begin
      @(negedge clk);
      if (mult_start) s0 = 1;
    end
    check("mid_started", 64'(s0), 64'(1));
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    req_valid = '0;
    #1 check_all_zero("mid_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    glog.delete();
    post(3, 16'h0011, 16'h0022, 4);
    post(1, 16'h00C3, 16'h005A, 4);
    wait_idle("idle_after_rst");
    check("post_rst_grants", 64'(glog.size()), 64'(2));
    if (glog.size() == 2) begin
      check("post_rst_first", 64'(glog[0]), 64'(1));
      check("post_rst_second", 64'(glog[1]), 64'(3));
    end

`ifdef SEQ_ARB_TIMEOUT_EN
    // Multiplier never finishes
    hang_mode = 1'b1;
    post(0, 16'h0005, 16'h0006, 3);
    wait_idle("idle_timeout");
    hang_mode = 1'b0;
`endif

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
